// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies and FSM state encoding.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic md_is_long(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU plus a
// divide-by-zero flag.
module md_result_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);

  logic signed [63:0] a_ext, b_ext, prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, div_b_s, div_b_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign div0 = (b == 32'd0);

  assign a_ext  = {{32{a[31]}}, a};
  assign b_ext  = {{32{b[31]}}, b};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_mag   = a[31] ? (~a + 32'd1) : a;
  assign b_mag   = b[31] ? (~b + 32'd1) : b;
  assign div_b_s = div0 ? 32'd1 : b_mag;
  assign div_b_u = div0 ? 32'd1 : b;
  assign q_mag   = a_mag / div_b_s;
  assign r_mag   = a_mag % div_b_s;
  assign q_s     = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s     = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u     = a / div_b_u;
  assign r_u     = a % div_b_u;

  always_comb begin
    res = 64'd0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {r_s, q_s};
      MD_DIVU:  res = {r_u, q_u};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers.
// Optional MD_CANCEL_EN adds the md_cancel flush input.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_src_a,
  input  logic [31:0] md_src_b,
`ifdef MD_CANCEL_EN
  input  logic        md_cancel,
`endif
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      shadow_hi, shadow_lo;
  logic             shadow_skip;
  logic [63:0]      calc_res;
  logic             calc_div0;
  logic             cancel_w;
  logic             last_cyc;
  logic             start_ok;

`ifdef MD_CANCEL_EN
  assign cancel_w = md_cancel;
`else
  assign cancel_w = 1'b0;
`endif

  md_result_calc u_calc (
    .op   (md_op),
    .a    (md_src_a),
    .b    (md_src_b),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  assign md_busy  = (state == ST_RUN);
  assign last_cyc = (state == ST_RUN) && (cnt == CNT_W'(1));
  // The final busy cycle behaves as idle for a new request.
  assign start_ok = md_start && ((state == ST_IDLE) || last_cyc) && !cancel_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shadow_hi   <= '0;
      shadow_lo   <= '0;
      shadow_skip <= 1'b0;
      md_hi       <= '0;
      md_lo       <= '0;
    end else if ((state == ST_RUN) && cancel_w) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      if (last_cyc) begin
        state <= ST_IDLE;
        cnt   <= '0;
        if (!shadow_skip) begin
          md_hi <= shadow_hi;
          md_lo <= shadow_lo;
        end
      end else if (state == ST_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Later assignments override the commit when a new op starts on the final cycle.
      if (start_ok) begin
        if (md_is_long(md_op)) begin
          state       <= ST_RUN;
          cnt         <= md_is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          shadow_hi   <= calc_res[63:32];
          shadow_lo   <= calc_res[31:0];
          shadow_skip <= md_is_div(md_op) && calc_div0;
        end else if (md_op == MD_MTHI) begin
          md_hi <= md_src_a;
        end else if (md_op == MD_MTLO) begin
          md_lo <= md_src_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed self-checking bench for md_unit_ctrl (cancel cases only when
// MD_CANCEL_EN is defined).
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_src_a, md_src_b;
`ifdef MD_CANCEL_EN
  logic        md_cancel;
`endif
  logic        md_busy;
  logic [31:0] md_hi, md_lo;

  int checks = 0;
  int errors = 0;
  int n;

  md_unit_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_start (md_start),
    .md_op    (md_op),
    .md_src_a (md_src_a),
    .md_src_b (md_src_b),
`ifdef MD_CANCEL_EN
    .md_cancel(md_cancel),
`endif
    .md_busy  (md_busy),
    .md_hi    (md_hi),
    .md_lo    (md_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    md_src_a = a;
    md_src_b = b;
    step();
    md_start = 1'b0;
    md_op    = 3'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (md_busy && cyc < 64) begin
      cyc++;
      step();
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    md_start = 1'b0;
    md_op    = 3'd0;
    md_src_a = '0;
    md_src_b = '0;
`ifdef MD_CANCEL_EN
    md_cancel = 1'b0;
`endif
    #3;
    chk("rst_busy", md_busy, 0);
    chk("rst_hi", md_hi, 0);
    chk("rst_lo", md_lo, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // MULT -3 * 5
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy", md_busy, 1);
    chk("mult_hold_lo", md_lo, 0);
    wait_idle(n);
    chk("mult_lat", n, 5);
    chk("mult_hi", md_hi, 32'hFFFF_FFFF);
    chk("mult_lo", md_lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_lat", n, 5);
    chk("multu_hi", md_hi, 32'hFFFF_FFFE);
    chk("multu_lo", md_lo, 32'h0000_0001);

    // DIV -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_hold_hi", md_hi, 32'hFFFF_FFFE);
    wait_idle(n);
    chk("div_lat", n, 10);
    chk("div_lo", md_lo, 32'hFFFF_FFFD);
    chk("div_hi", md_hi, 32'hFFFF_FFFF);

    // DIVU 7 / 2
    issue(3'd4, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", md_lo, 3);
    chk("divu_hi", md_hi, 1);

    // DIVU by zero leaves HI/LO alone
    issue(3'd4, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_lat", n, 10);
    chk("div0_hi", md_hi, 1);
    chk("div0_lo", md_lo, 3);

    // DIV 0x80000000 / -1
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", md_lo, 32'h8000_0000);
    chk("divovf_hi", md_hi, 0);

    // MTHI / MTLO
    issue(3'd5, 32'h0000_1234, 32'd0);
    chk("mthi_busy", md_busy, 0);
    chk("mthi_hi", md_hi, 32'h0000_1234);
    chk("mthi_lo", md_lo, 32'h8000_0000);
    issue(3'd6, 32'h0000_ABCD, 32'd0);
    chk("mtlo_lo", md_lo, 32'h0000_ABCD);
    chk("mtlo_busy", md_busy, 0);

    // Ops 0 and 7 do nothing
    issue(3'd0, 32'h5A5A_5A5A, 32'd3);
    issue(3'd7, 32'h5A5A_5A5A, 32'd3);
    chk("nop_busy", md_busy, 0);
    chk("nop_hi", md_hi, 32'h0000_1234);
    chk("nop_lo", md_lo, 32'h0000_ABCD);

    // MTLO while busy is ignored
    issue(3'd1, 32'd2, 32'd3);
    step();
    issue(3'd6, 32'h0000_5555, 32'd0);
    chk("mtlo_busy_busy", md_busy, 1);
    chk("mtlo_busy_lo", md_lo, 32'h0000_ABCD);
    wait_idle(n);
    chk("mtlo_busy_rem", n, 3);
    chk("mult23_lo", md_lo, 6);
    chk("mult23_hi", md_hi, 0);

    // MULT then DIVU started on the final busy cycle
    issue(3'd1, 32'd4, 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy", md_busy, 1);
      chk("b2b_hold_lo", md_lo, 6);
      step();
    end
    issue(3'd4, 32'd100, 32'd7);
    chk("b2b_busy_cont", md_busy, 1);
    chk("b2b_mult_lo", md_lo, 20);
    chk("b2b_mult_hi", md_hi, 0);
    wait_idle(n);
    chk("b2b_div_lat", n, 10);
    chk("b2b_div_lo", md_lo, 14);
    chk("b2b_div_hi", md_hi, 2);

`ifdef MD_CANCEL_EN
    // Cancel at busy cycle 3 of DIVU
    issue(3'd4, 32'd9, 32'd2);
    step();
    step();
    md_cancel = 1'b1;
    step();
    md_cancel = 1'b0;
    chk("cancel_busy", md_busy, 0);
    for (int i = 0; i < 12; i++) step();
    chk("cancel_hi", md_hi, 2);
    chk("cancel_lo", md_lo, 14);
    // Cancel together with MTHI suppresses the write
    md_cancel = 1'b1;
    issue(3'd5, 32'h0000_DEAD, 32'd0);
    md_cancel = 1'b0;
    chk("cancel_mthi_hi", md_hi, 2);
    chk("cancel_mthi_busy", md_busy, 0);
`endif

    // Reset in the middle of a MULT
    issue(3'd1, 32'd7, 32'd9);
    step();
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", md_busy, 0);
    chk("rstmid_hi", md_hi, 0);
    chk("rstmid_lo", md_lo, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rstmid_no_commit_lo", md_lo, 0);
    chk("rstmid_no_commit_busy", md_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
